// File: rtl/bus_master_arbiter_if.sv
// Requester-side and simple_bus-side signals of bus_master_arbiter.
// The arbiter takes the master modport; its environment takes the slave modport.
interface bus_master_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32
);
  logic [NUM_MASTERS-1:0]        rq_valid;
  logic [NUM_MASTERS-1:0]        rq_we;
  logic [NUM_MASTERS*ADDR_W-1:0] rq_addr;
  logic [NUM_MASTERS*DATA_W-1:0] rq_wdata;
  logic [NUM_MASTERS-1:0]        rq_ready;
  logic [DATA_W-1:0]             rq_rdata;
  logic                          rq_err;

  logic [ADDR_W-1:0]             m_addr;
  logic [DATA_W-1:0]             m_wdata;
  logic                          m_we;
  logic                          m_valid;
  logic                          m_ready;
  logic [DATA_W-1:0]             m_rdata;

  logic [NUM_MASTERS-1:0]        grant;
  logic                          busy;

  modport master (
    input  rq_valid, rq_we, rq_addr, rq_wdata, m_ready, m_rdata,
    output rq_ready, rq_rdata, rq_err, m_addr, m_wdata, m_we, m_valid, grant, busy
  );

  modport slave (
    output rq_valid, rq_we, rq_addr, rq_wdata, m_ready, m_rdata,
    input  rq_ready, rq_rdata, rq_err, m_addr, m_wdata, m_we, m_valid, grant, busy
  );
endinterface

// File: rtl/bus_master_arbiter.sv
// Round-robin arbiter sharing the single simple_bus master port between NUM_MASTERS
// requesters; one transfer at a time, with an optional m_ready timeout.
module bus_master_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT     = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  bus_master_arbiter_if.master bus
);

  localparam int PTR_W = $clog2(NUM_MASTERS);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [NUM_MASTERS-1:0] ONE = NUM_MASTERS'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t           state, next_state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] win_idx;
  logic             win_found;
  logic [PTR_W-1:0] ptr_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             bus_done;
  logic             bus_timeout;

  // First requester at or above ptr, wrapping; ptr itself has highest priority.
  always_comb begin
    logic [PTR_W-1:0] cand;
    // NOTE: every variable written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    cand      = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand = PTR_W'((int'(ptr) + i) % NUM_MASTERS);
      if (!win_found && bus.rq_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign ptr_next    = PTR_W'((int'(gnt_idx) + 1) % NUM_MASTERS);
  assign bus_done    = (state == ISSUE) && bus.m_valid && bus.m_ready;
  assign bus_timeout = (state == ISSUE) && !bus.m_ready && (TIMEOUT != 0) &&
                       (wait_cnt == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (win_found) next_state = ISSUE;
      ISSUE:   if (bus_done || bus_timeout) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == ISSUE) || (state == DONE);
  end

  // Bus request fields are captured once at arbitration and stay frozen through ISSUE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.m_addr   <= '0;
      bus.m_wdata  <= '0;
      bus.m_we     <= 1'b0;
      bus.m_valid  <= 1'b0;
      bus.rq_ready <= '0;
      bus.rq_rdata <= '0;
      bus.rq_err   <= 1'b0;
      bus.grant    <= '0;
      ptr          <= '0;
      gnt_idx      <= '0;
      wait_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            bus.m_addr  <= bus.rq_addr[win_idx*ADDR_W +: ADDR_W];
            bus.m_wdata <= bus.rq_wdata[win_idx*DATA_W +: DATA_W];
            bus.m_we    <= bus.rq_we[win_idx];
            bus.m_valid <= 1'b1;
            bus.grant   <= ONE << win_idx;
            gnt_idx     <= win_idx;
            wait_cnt    <= '0;
          end
        end
        ISSUE: begin
          if (bus_done) begin
            bus.m_valid  <= 1'b0;
            bus.rq_rdata <= bus.m_we ? '0 : bus.m_rdata;
            bus.rq_ready <= bus.grant;
            bus.rq_err   <= 1'b0;
            ptr          <= ptr_next;
          end else if (bus_timeout) begin
            bus.m_valid  <= 1'b0;
            bus.rq_rdata <= '0;
            bus.rq_ready <= bus.grant;
            bus.rq_err   <= 1'b1;
            ptr          <= ptr_next;
          end else if (TIMEOUT != 0) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          bus.rq_ready <= '0;
          bus.rq_rdata <= '0;
          bus.rq_err   <= 1'b0;
          bus.grant    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Directed self-checking bench for bus_master_arbiter (4 masters, TIMEOUT=16).
module tb_bus_master_arbiter;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  int   cyc;

  bus_master_arbiter_if #(.NUM_MASTERS(4), .ADDR_W(8), .DATA_W(32)) bus ();

  bus_master_arbiter #(
    .NUM_MASTERS(4),
    .ADDR_W     (8),
    .DATA_W     (32),
    .TIMEOUT    (16)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {bus.m_valid, bus.m_we, bus.rq_err, bus.busy, bus.rq_ready, bus.grant}, 64'd0);
    check({tag, "_addr"}, bus.m_addr, 64'd0);
    check({tag, "_wdata"}, bus.m_wdata, 64'd0);
    check({tag, "_rdata"}, bus.rq_rdata, 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One 3-cycle transfer with m_ready already high: IDLE->ISSUE, ISSUE->DONE, DONE->IDLE.
  task automatic run_xfer(input string tag, input logic [3:0] g);
    tick();
    check({tag, "_grant"}, bus.grant, g);
    check({tag, "_mvalid"}, bus.m_valid, 1'b1);
    tick();
    check({tag, "_rqready"}, bus.rq_ready, g);
    tick();
    check({tag, "_idle"}, {bus.grant, bus.busy}, 5'd0);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    reset_n      = 1'b0;
    bus.rq_valid = '0;
    bus.rq_we    = '0;
    bus.rq_addr  = '0;
    bus.rq_wdata = '0;
    bus.m_ready  = 1'b0;
    bus.m_rdata  = '0;
    #1;
    check_all_zero("por");
    @(negedge clk);
    reset_n = 1'b1;

    // Single write from master 0
    bus.rq_valid       = 4'b0001;
    bus.rq_we          = 4'b0001;
    bus.rq_addr[7:0]   = 8'h10;
    bus.rq_wdata[31:0] = 32'h1122_3344;
    bus.m_ready        = 1'b1;
    tick();
    check("wr_issue", {bus.m_valid, bus.m_we, bus.busy, bus.grant, bus.rq_ready}, {3'b111, 4'b0001, 4'b0000});
    check("wr_addr", bus.m_addr, 8'h10);
    check("wr_wdata", bus.m_wdata, 32'h1122_3344);
    tick();
    check("wr_done", {bus.m_valid, bus.rq_err, bus.rq_ready}, {2'b00, 4'b0001});
    bus.rq_valid = '0;
    tick();
    check("wr_idle", {bus.rq_ready, bus.grant, bus.busy}, 9'd0);

    // Read from master 2
    bus.rq_valid        = 4'b0100;
    bus.rq_we           = 4'b0000;
    bus.rq_addr[23:16]  = 8'h20;
    bus.m_rdata         = 32'hABCD_1234;
    tick();
    check("rd_issue", {bus.m_we, bus.grant}, {1'b0, 4'b0100});
    check("rd_addr", bus.m_addr, 8'h20);
    tick();
    check("rd_ready", bus.rq_ready, 4'b0100);
    check("rd_rdata", bus.rq_rdata, 32'hABCD_1234);
    bus.rq_valid = '0;
    tick();
    check("rd_clear", bus.rq_rdata, 32'd0);

    // Simultaneous requests after reset
    do_reset();
    bus.rq_valid = 4'b1010;
    run_xfer("sim0", 4'b0010);
    run_xfer("sim1", 4'b1000);
    run_xfer("sim2", 4'b0010);
    bus.rq_valid = '0;

    // Fairness with all four requesting
    do_reset();
    bus.rq_valid = 4'b1111;
    run_xfer("fair0", 4'b0001);
    run_xfer("fair1", 4'b0010);
    run_xfer("fair2", 4'b0100);
    run_xfer("fair3", 4'b1000);
    run_xfer("fair4", 4'b0001);
    run_xfer("fair5", 4'b0010);
    bus.rq_valid = '0;

    // Timeout on a read from master 1, with its address changing mid-transfer
    do_reset();
    bus.rq_valid       = 4'b0010;
    bus.rq_we          = 4'b0000;
    bus.rq_addr[15:8]  = 8'h33;
    bus.m_ready        = 1'b0;
    bus.m_rdata        = 32'hDEAD_BEEF;
    tick();
    check("to_grant", bus.grant, 4'b0010);
    cyc = 0;
    while (bus.m_valid === 1'b1 && cyc < 40) begin
      cyc++;
      if (cyc == 3) bus.rq_addr[15:8] = 8'h77;
      tick();
    end
    check("to_valid_cycles", cyc, 16);
    check("to_addr_frozen", bus.m_addr, 8'h33);
    check("to_ready", bus.rq_ready, 4'b0010);
    check("to_err", bus.rq_err, 1'b1);
    check("to_rdata", bus.rq_rdata, 32'd0);
    bus.rq_valid = '0;
    tick();
    check("to_clear", {bus.rq_err, bus.rq_ready, bus.grant}, 9'd0);
    bus.rq_valid = 4'b0111;
    bus.m_ready  = 1'b1;
    run_xfer("to_next", 4'b0100);

    // Reset during ISSUE
    bus.rq_valid = 4'b0001;
    bus.m_ready  = 1'b0;
    tick();
    check("mid_issue", {bus.m_valid, bus.grant}, {1'b1, 4'b0001});
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk);
    check("mid_no_ready", bus.rq_ready, 4'b0000);
    bus.rq_valid = 4'b1111;
    bus.m_ready  = 1'b1;
    reset_n      = 1'b1;
    run_xfer("post_rst", 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_master_arbiter.md
# bus_master_arbiter

Round-robin arbiter that shares the single master port of `simple_bus` between `NUM_MASTERS` requesters. It latches one request at a time and drives it onto the bus with a valid/ready handshake. It returns read data, or a timeout error, to the winning requester. It sits directly in front of `simple_bus`'s `m_*` port and owns that port exclusively.

## Interface
- `NUM_MASTERS`, 4, number of requesters (2–8)
- `ADDR_W`, 8, address width
- `DATA_W`, 32, data width
- `TIMEOUT`, 16, max cycles `m_valid` may wait for `m_ready`; 0 = no timeout

Ports. One clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock, all logic on rising edge
- `reset_n`  in  1  asynchronous active-low reset
- `rq_valid`  in  NUM_MASTERS  request pending per master; held until that master's `rq_ready`
- `rq_we`  in  NUM_MASTERS  1 = write, 0 = read, per master
- `rq_addr`  in  NUM_MASTERS*ADDR_W  packed addresses; master i at [i*ADDR_W +: ADDR_W]
- `rq_wdata`  in  NUM_MASTERS*DATA_W  packed write data; master i at [i*DATA_W +: DATA_W]
- `rq_ready`  out  NUM_MASTERS  one-cycle completion pulse, one-hot
- `rq_rdata`  out  DATA_W  read data, valid while `rq_ready` is high
- `rq_err`  out  1  high with `rq_ready` when the transfer timed out
- `m_addr`  out  ADDR_W  to simple_bus
- `m_wdata`  out  DATA_W  to simple_bus
- `m_we`  out  1  to simple_bus
- `m_valid`  out  1  to simple_bus
- `m_ready`  in  1  from simple_bus
- `m_rdata`  in  DATA_W  from simple_bus
- `grant`  out  NUM_MASTERS  one-hot current owner; 0 in IDLE
- `busy`  out  1  high in ISSUE and DONE

## Operation
- **State machine:** IDLE, ISSUE, DONE.
- **IDLE → ISSUE:** taken when any `rq_valid` bit is high.
  - The winner is the first set bit scanning upward from `ptr`, wrapping modulo NUM_MASTERS.
  - On the same edge: register the winner's addr/wdata/we into `m_*`, set `grant`, set `m_valid=1`, clear the timeout counter.
- **ISSUE, normal completion:** when `m_valid && m_ready` on an edge:
  - `m_valid←0`; `rq_rdata←m_rdata` (reads only; writes give 0).
  - `rq_ready[g]←1`, `rq_err←0`, `ptr←(g+1) mod NUM_MASTERS`; go to DONE.
- **ISSUE, waiting:** otherwise the counter increments.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT-1 with no `m_ready`: `m_valid←0`, `rq_rdata←0`, `rq_err←1`, `rq_ready[g]←1`, advance `ptr`; go to DONE.
- **ISSUE invariant:** `m_addr`/`m_wdata`/`m_we` stay constant for the whole ISSUE state. Requester inputs changing mid-transfer have no effect.
- **DONE:** `rq_ready`, `rq_err` and `rq_rdata` are held for exactly this one cycle. Then clear `rq_ready`, `rq_err` and `grant`; go to IDLE. No arbitration happens in DONE.
- **Requester obligation:** on the edge a requester samples its `rq_ready` high, it drops `rq_valid` or presents its next request.
- **`ptr`:** advances only on completion (normal or timeout); never advances in IDLE.
- **Reset (any state, including mid-transfer):** every output goes to 0 immediately, `ptr=0`, state IDLE. The aborted transfer gets no `rq_ready` pulse.

## Timing
- **Reset values:** `m_addr=0`, `m_wdata=0`, `m_we=0`, `m_valid=0`, `rq_ready=0`, `rq_rdata=0`, `rq_err=0`, `grant=0`, `busy=0`.
- **Request to bus:** `rq_valid` sampled high in IDLE at edge E0 → `m_valid` high from E0 (registered output, visible the cycle after E0).
- **Bus to completion:** `m_ready` sampled at edge E1 → `rq_ready` high for the cycle after E1 → IDLE after E1+1.
- **Minimum transfer:** with `m_ready` tied high, 3 cycles from request to next arbitration (IDLE, ISSUE, DONE).
- **Timeout:** `m_valid` stays high for exactly TIMEOUT cycles, then `rq_err` pulses.
- **Simultaneous requests:** all evaluated in the same IDLE cycle; exactly one bit of `grant` is set.
- **Wrap-around:** after master NUM_MASTERS-1 completes, `ptr=0`.

## Test plan
- **Single write:** master 0 writes addr 8'h10, data 32'h11223344, `m_ready`=1.
  - `m_valid` high 1 cycle with those values and `m_we`=1; `rq_ready`=4'b0001 one cycle later; `rq_err`=0.
- **Read return:** master 2 reads addr 8'h20, `m_rdata`=32'hABCD_1234.
  - `rq_rdata`=32'hABCD_1234 while `rq_ready`=4'b0100.
- **Simultaneous requests after reset:** `rq_valid`=4'b1010 held.
  - Grants in order 4'b0010 then 4'b1000, then back to 4'b0010.
- **Fairness:** all four masters requesting continuously.
  - Grant sequence 0,1,2,3,0,1 with one transfer every 3 cycles.
- **Timeout:** master 1 reads, `m_ready` held 0, TIMEOUT=16.
  - `m_valid` high exactly 16 cycles; then `rq_ready`=4'b0010, `rq_err`=1, `rq_rdata`=0; next grant starts from master 2.
- **Reset mid-transfer:** `reset_n` pulsed low during ISSUE.
  - All outputs 0 immediately, no `rq_ready` pulse; after release, `rq_valid`=4'b1111 grants master 0 first.
